// File: rtl/bus_window_decode.sv
// Multi-window chip-enable decoder for the CPU bus, with wait-stated DTACK
// and bus error on writes to read-only windows.
module bus_window_decode #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DEC_LSB  = 16,
  parameter int unsigned N_WIN    = 2,
  parameter logic [N_WIN*(ADDR_W-DEC_LSB)-1:0] WIN_BASE = {8'hF2, 8'hF1},
  parameter logic [N_WIN*(ADDR_W-DEC_LSB)-1:0] WIN_MASK = {8'hFF, 8'hFF},
  parameter logic [N_WIN-1:0] RO_MASK = 2'b10,
  parameter int unsigned WAIT_CYC = 2,
  parameter bit          SYNC_AS  = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [ADDR_W-DEC_LSB-1:0] A,
  input  logic                      AS,
  input  logic                      RW,
  output logic [N_WIN-1:0]          CE,
  output logic                      DTACK,
  output logic                      BERR,
  output logic                      BUSY
);

  localparam int unsigned DW = ADDR_W - DEC_LSB;
  localparam int unsigned IW = (N_WIN > 1) ? $clog2(N_WIN) : 1;
  localparam logic [3:0]  CNT_LAST = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             err;
  logic             as_smp;
  logic             hit;
  logic [IW-1:0]    idx;
  logic             ro_write;
  logic [N_WIN-1:0] ce_sel;

  generate
    if (SYNC_AS) begin : g_sync
      logic as_s1;
      logic as_s2;
      always_ff @(posedge CLK) begin
        if (!RESET) begin
          as_s1 <= 1'b1;
          as_s2 <= 1'b1;
        end else begin
          as_s1 <= AS;
          as_s2 <= as_s1;
        end
      end
      assign as_smp = as_s2;
    end else begin : g_nosync
      assign as_smp = AS;
    end
  endgenerate

  // Priority decode: scanning downward leaves the lowest matching index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (((A ^ WIN_BASE[i*DW +: DW]) & WIN_MASK[i*DW +: DW]) == '0) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

  assign ro_write = RO_MASK[idx] && !RW;
  assign ce_sel   = ~(N_WIN'(1) << idx);
  assign BUSY     = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_IDLE;
      CE    <= '1;
      DTACK <= 1'b1;
      BERR  <= 1'b1;
      cnt   <= 4'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!as_smp) begin
            if (!hit) begin
              state <= S_HOLD;
            end else begin
              cnt <= 4'd0;
              err <= ro_write;
              if (!ro_write) CE <= ce_sel;
              if (WAIT_CYC == 0) begin
                state <= S_ACK;
                if (ro_write) BERR  <= 1'b0;
                else          DTACK <= 1'b0;
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (as_smp) begin
            state <= S_IDLE;
            CE    <= '1;
            DTACK <= 1'b1;
            BERR  <= 1'b1;
          end else begin
            if (cnt != 4'd15) cnt <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
              state <= S_ACK;
              if (err) BERR  <= 1'b0;
              else     DTACK <= 1'b0;
            end
          end
        end
        S_ACK: begin
          if (as_smp) begin
            state <= S_IDLE;
            CE    <= '1;
            DTACK <= 1'b1;
            BERR  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (as_smp) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_window_decode.md
Name: bus_window_decode

Overview:
- Parametrised successor to the single-window Falcon chip-enable decoder on the ethernet card's CPU bus.
- Decodes up to N_WIN address windows from the upper address lines and drives one registered active-low chip enable per window.
- Generates a wait-stated DTACK for each access, plus BERR for writes to read-only windows.
- Holds every output for the whole bus cycle, until AS deasserts.

Parameters:
- ADDR_W, 24: width of the full CPU address bus.
- DEC_LSB, 16: lowest address bit used for decoding; the decoded field is A[ADDR_W-1:DEC_LSB], width DW = ADDR_W-DEC_LSB.
- N_WIN, 2: number of windows (1..8).
- WIN_BASE, {8'hF2,8'hF1}: packed N_WIN*DW bits. Window i occupies bits [i*DW +: DW].
- WIN_MASK, {8'hFF,8'hFF}: packed N_WIN*DW bits. A 1 means the bit is compared; a 0 means don't-care.
- RO_MASK, 2'b10: bit i = 1 makes window i read-only.
- WAIT_CYC, 2: clocks from the CE assertion edge to the DTACK/BERR assertion edge (0..15).
- SYNC_AS, 0: 1 inserts a 2-flop synchroniser on AS, adding 2 cycles to the start latency.

Ports:
- CLK, input, 1: bus clock.
- RESET, input, 1: active-low reset, synchronous to CLK.
- A, input, ADDR_W-DEC_LSB: address bits [ADDR_W-1:DEC_LSB].
- AS, input, 1: address strobe, active low.
- RW, input, 1: 1 = read, 0 = write.
- CE, output, N_WIN: chip enables, active low, registered.
- DTACK, output, 1: data acknowledge, active low, registered.
- BERR, output, 1: bus error, active low, registered.
- BUSY, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: on any rising CLK edge with RESET=0 the block enters the reset state, and reset overrides all other inputs.
- Reset state: CE all 1, DTACK=1, BERR=1, BUSY=0, FSM=IDLE, counter=0, synchroniser flops=1.
- Sampled strobe: ASs = AS when SYNC_AS=0, otherwise the 2-flop synchronised AS. A and RW are sampled raw; they are stable while AS is low.
- Window i matches when ((A ^ WIN_BASE[i]) & WIN_MASK[i]) == 0.
- If several windows match, the lowest index wins. The winning index is latched as W.

FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE, ASs=1: stay in IDLE.
- IDLE, ASs=0, no match: go to HOLD. All outputs stay high; another device owns the cycle.
- IDLE, ASs=0, match W, RO_MASK[W]=0 or RW=1: at the next edge CE[W]=0, counter=0, go to WAIT. With WAIT_CYC=0, DTACK=0 on the same edge and the FSM goes straight to ACK.
- IDLE, ASs=0, match W, RO_MASK[W]=1 and RW=0: CE stays high, error flag set, go to WAIT. With WAIT_CYC=0, BERR=0 on the same edge and the FSM goes to ACK.
- WAIT: counter increments every edge. When counter reaches WAIT_CYC-1, the next edge asserts DTACK=0 (or BERR=0 if the error flag is set) and the FSM goes to ACK. DTACK therefore asserts exactly WAIT_CYC edges after CE asserts.
- WAIT, ASs=1 (aborted cycle): at the next edge all outputs go high and the FSM returns to IDLE. DTACK/BERR never assert.
- ACK: CE[W] and DTACK (or BERR) are held low while ASs=0. The first edge that samples ASs=1 releases all outputs high and returns to IDLE.
- HOLD: wait for ASs=1, then return to IDLE. A is not re-decoded inside a cycle, so late address changes are ignored.
- A new cycle can only begin from IDLE, which requires at least one ASs=1 sample between cycles.
- DTACK and BERR are never both low. At most one CE bit is low at any time.
- The counter is wide enough for 15 and never wraps; it is cleared on every entry to WAIT.
- Reset asserted mid-cycle (WAIT or ACK): all outputs go high at that edge. After reset releases, if AS is still low, the cycle is decoded afresh as a new cycle.
- Latency, IDLE to CE low, is one edge after ASs is sampled low; add 2 edges when SYNC_AS=1.

Test Plan:
1. Reset and idle: RESET=0 for 3 clocks with AS=0, A=8'hF1 -> CE=2'b11, DTACK=1, BERR=1, BUSY=0 at every edge.
2. Read of window 0, defaults: A=8'hF1, RW=1, AS falls -> CE=2'b10 one edge later, DTACK=0 two edges after that, both held until AS rises, then all high one edge later.
3. Write to read-only window 1: A=8'hF2, RW=0, AS low -> CE stays 2'b11, BERR=0 three edges after AS is sampled, DTACK stays 1, all released after AS rises.
4. Miss and abort: A=8'h00, AS low for 5 clocks -> FSM in HOLD, outputs high, and changing A to 8'hF1 mid-cycle causes no CE. Separately, A=8'hF1 with AS rising one edge after CE asserts -> CE released, DTACK never low.
5. Overlap and parameter sweep: WIN_MASK[0]=8'hF0, WIN_BASE[0]=8'hF0, A=8'hF2 -> CE[0] asserts, not CE[1]. With WAIT_CYC=0 -> CE and DTACK fall on the same edge. With SYNC_AS=1 -> CE asserts 3 edges after AS falls.
6. Reset mid-ACK: RESET=0 for one edge while DTACK=0 and AS is held low -> all outputs high at that edge. After release, a fresh decode asserts CE again one edge later.
